// File: rtl/knn_topk_sorter_pkg.sv
// Shared definitions for the streaming K-nearest-neighbour selector:
// FSM state encoding and the squared-distance width rule.
package knn_topk_sorter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } knnState_e;

   // dx and dy each span DATA_W+1 bits, so dx*dx + dy*dy needs 2*DATA_W+1 bits
   function automatic int knnDistW(input int dataW);
      return 2 * dataW + 1;
   endfunction

endpackage

// File: rtl/knn_topk_sorter_dist.sv
// Two-stage registered squared-distance pipeline (S1: dx/dy, S2: dx^2+dy^2)
// carrying valid, index, label and last sidebands alongside the data.
module knn_dist
   import knn_topk_sorter_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int IDX_W   = 8,
   parameter int LABEL_W = 8,
   parameter int DIST_W  = knnDistW(DATA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_flush,
   input  logic               i_vld,
   input  logic [DATA_W-1:0]  i_x,
   input  logic [DATA_W-1:0]  i_y,
   input  logic [DATA_W-1:0]  i_testX,
   input  logic [DATA_W-1:0]  i_testY,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic [LABEL_W-1:0] i_label,
   input  logic               i_last,
   output logic               o_vld,
   output logic [DIST_W-1:0]  o_dist,
   output logic [IDX_W-1:0]   o_idx,
   output logic [LABEL_W-1:0] o_label,
   output logic               o_last
);

   localparam int PROD_W = 2 * DATA_W + 2;

   logic signed [DATA_W:0]   w_dx, w_dy;
   logic signed [DATA_W:0]   r_dx, r_dy;
   logic                     r_s1Vld, r_s1Last;
   logic [IDX_W-1:0]         r_s1Idx;
   logic [LABEL_W-1:0]       r_s1Label;
   logic signed [PROD_W-1:0] w_dxExt, w_dyExt, w_sqX, w_sqY;
   logic [DIST_W-1:0]        w_dist;

   // One extra bit holds any difference of two DATA_W-bit signed values exactly
   assign w_dx = {i_x[DATA_W-1], i_x} - {i_testX[DATA_W-1], i_testX};
   assign w_dy = {i_y[DATA_W-1], i_y} - {i_testY[DATA_W-1], i_testY};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Vld   <= 1'b0;
         r_s1Last  <= 1'b0;
         r_dx      <= '0;
         r_dy      <= '0;
         r_s1Idx   <= '0;
         r_s1Label <= '0;
      end else begin
         r_s1Vld <= i_vld & ~i_flush;
         if (i_vld) begin
            r_dx      <= w_dx;
            r_dy      <= w_dy;
            r_s1Idx   <= i_idx;
            r_s1Label <= i_label;
            r_s1Last  <= i_last;
         end
      end
   end

   assign w_dxExt = PROD_W'(r_dx);
   assign w_dyExt = PROD_W'(r_dy);
   assign w_sqX   = w_dxExt * w_dxExt;
   assign w_sqY   = w_dyExt * w_dyExt;
   assign w_dist  = DIST_W'(w_sqX) + DIST_W'(w_sqY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vld   <= 1'b0;
         o_dist  <= '0;
         o_idx   <= '0;
         o_label <= '0;
         o_last  <= 1'b0;
      end else begin
         o_vld <= r_s1Vld & ~i_flush;
         if (r_s1Vld) begin
            o_dist  <= w_dist;
            o_idx   <= r_s1Idx;
            o_label <= r_s1Label;
            o_last  <= r_s1Last;
         end
      end
   end

endmodule

// File: rtl/knn_topk_sorter.sv
// Streaming top-K nearest-neighbour selector: distance pipeline feeding a
// parallel-insert sorted list, run/drain/done FSM and rank-addressed readout.
module knn_topk_sorter
   import knn_topk_sorter_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int K       = 8,
   parameter  int IDX_W   = 8,
   parameter  int LABEL_W = 8,
   parameter  int SEL_W   = 5,
   localparam int DIST_W  = knnDistW(DATA_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DATA_W-1:0]  test_x,
   input  logic [DATA_W-1:0]  test_y,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_x,
   input  logic [DATA_W-1:0]  in_y,
   input  logic [LABEL_W-1:0] in_label,
   input  logic               in_last,
   input  logic [SEL_W-1:0]   sel,
   output logic [DIST_W-1:0]  out_dist,
   output logic [IDX_W-1:0]   out_idx,
   output logic [LABEL_W-1:0] out_label,
   output logic               out_vld,
   output logic               done,
   output logic               ovf
);

   localparam logic [IDX_W-1:0] IDX_MAX = '1;

   knnState_e          r_state, w_nextState;
   logic               w_accept;
   logic [IDX_W-1:0]   r_cnt;
   logic               r_cntTop;
   logic               w_s2Vld, w_s2Last;
   logic [DIST_W-1:0]  w_s2Dist;
   logic [IDX_W-1:0]   w_s2Idx;
   logic [LABEL_W-1:0] w_s2Label;

   logic [DIST_W-1:0]  r_dist [K];
   logic [IDX_W-1:0]   r_idx  [K];
   logic [LABEL_W-1:0] r_lbl  [K];
   logic               r_vld  [K];
   logic [DIST_W-1:0]  w_pDist [K];
   logic [IDX_W-1:0]   w_pIdx  [K];
   logic [LABEL_W-1:0] w_pLbl  [K];
   logic               w_pVld  [K];
   logic [K-1:0]       w_lt, w_ltPrev;

   // start wins over a same-cycle handshake, so that sample never enters the pipe
   assign w_accept = in_valid & in_ready & ~start;

   // Index counter stops at its top value; r_cntTop marks that the top index is taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_cntTop <= 1'b0;
         ovf      <= 1'b0;
      end else if (start) begin
         r_cnt    <= '0;
         r_cntTop <= 1'b0;
         ovf      <= 1'b0;
      end else if (w_accept) begin
         if (r_cntTop)
            ovf <= 1'b1;
         else if (r_cnt == IDX_MAX)
            r_cntTop <= 1'b1;
         else
            r_cnt <= r_cnt + 1'b1;
      end
   end

   knn_dist #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .LABEL_W(LABEL_W),
      .DIST_W (DIST_W)
   ) u_dist (
      .clk    (clk),
      .rst_n  (rst),
      .i_flush(start),
      .i_vld  (w_accept),
      .i_x    (in_x),
      .i_y    (in_y),
      .i_testX(test_x),
      .i_testY(test_y),
      .i_idx  (r_cnt),
      .i_label(in_label),
      .i_last (in_last),
      .o_vld  (w_s2Vld),
      .o_dist (w_s2Dist),
      .o_idx  (w_s2Idx),
      .o_label(w_s2Label),
      .o_last (w_s2Last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_nextState;
   end

   // Leaving DRAIN as the last sample sits in S2 lines done up with its insertion
   always_comb begin
      w_nextState = r_state;
      if (start)
         w_nextState = ST_RUN;
      else begin
         case (r_state)
            ST_RUN:   if (w_accept && in_last)  w_nextState = ST_DRAIN;
            ST_DRAIN: if (w_s2Vld && w_s2Last)  w_nextState = ST_DONE;
            default:  ;
         endcase
      end
   end

   always_comb begin
      in_ready = (r_state == ST_RUN);
      done     = (r_state == ST_DONE);
   end

   assign w_ltPrev = w_lt << 1;

   // Each slot either takes its upper neighbour, takes the new entry, or holds
   for (genvar i = 0; i < K; i++) begin : g_slot
      assign w_lt[i] = !r_vld[i] || (w_s2Dist < r_dist[i]);

      if (i == 0) begin : g_head
         assign w_pDist[i] = '1;
         assign w_pIdx[i]  = '0;
         assign w_pLbl[i]  = '0;
         assign w_pVld[i]  = 1'b0;
      end else begin : g_tail
         assign w_pDist[i] = r_dist[i-1];
         assign w_pIdx[i]  = r_idx[i-1];
         assign w_pLbl[i]  = r_lbl[i-1];
         assign w_pVld[i]  = r_vld[i-1];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_dist[i] <= '1;
            r_idx[i]  <= '0;
            r_lbl[i]  <= '0;
            r_vld[i]  <= 1'b0;
         end else if (start) begin
            r_dist[i] <= '1;
            r_idx[i]  <= '0;
            r_lbl[i]  <= '0;
            r_vld[i]  <= 1'b0;
         end else if (w_s2Vld) begin
            if (w_ltPrev[i]) begin
               r_dist[i] <= w_pDist[i];
               r_idx[i]  <= w_pIdx[i];
               r_lbl[i]  <= w_pLbl[i];
               r_vld[i]  <= w_pVld[i];
            end else if (w_lt[i]) begin
               r_dist[i] <= w_s2Dist;
               r_idx[i]  <= w_s2Idx;
               r_lbl[i]  <= w_s2Label;
               r_vld[i]  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      out_dist  = '0;
      out_idx   = '0;
      out_label = '0;
      out_vld   = 1'b0;
      for (int i = 0; i < K; i++) begin
         if (sel == SEL_W'(i)) begin
            out_dist  = r_dist[i];
            out_idx   = r_idx[i];
            out_label = r_lbl[i];
            out_vld   = r_vld[i];
         end
      end
   end

endmodule
